spi_master_nch: RTL and testbench

//  Parametrised SPI master: configurable word width, clock divider, NUM_CS chip selects.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 34 +++
 rtl/spi_master_nch.sv | 188 ++++++++++++++++++
 tb/tb_spi_master_nch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Package: spi_pkg
// Purpose: shared definitions for the spi_master_nch slice.
//   - state_t : FSM state encodings (also driven out on the debug 'state' port)
//   - MODE0..MODE3 : SPI mode constants, encoded as {CPOL, CPHA}
//   - cs_active() : true for the states in which a chip select is driven low
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic cs_active(input state_t s);
    return (s == SETUP) || (s == XFER) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Module: spi_clk_div
// Purpose: half-period timer for the SPI master. Emits a one-cycle tick on the
//   CLK_DIV-th clock after it was last cleared, then every CLK_DIV clocks.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   clr   in  restart the half-period (asserted on every FSM state change)
//   tick  out end of the current half-period
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_nch.sv
// Module: spi_master_nch
// Purpose: full-duplex SPI master, DATA_W bits per transfer, NUM_CS active-low
//   chip selects, spi_clk half-period of CLK_DIV system clocks, CPOL/CPHA chosen
//   per transfer.
// Optional build macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first input
//   (latched with start; 1 = LSB shifted out first and received bits fill data_rd
//   from bit 0 upward). Without it every transfer is MSB first.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   start                transfer request, only looked at in IDLE
//   polarity, phase      CPOL / CPHA for the next transfer
//   cs_sel               chip select index for the next transfer
//   data_wr              word to transmit
//   lsb_first            (macro builds only) bit order for the next transfer
//   miso                 serial input from the slave
//   spi_clk, cs_n, mosi  SPI pins
//   data_rd              last received word, valid from the done pulse onward
//   busy, done           transfer status / one-cycle completion pulse
//   state                current FSM state (debug)
// Handshake: start is accepted on any rising edge where state is IDLE; busy is
//   high for SETUP/XFER/HOLD and low again in the DONE cycle, where done pulses
//   for exactly one clock. A start seen while not IDLE is dropped, not queued.
module spi_master_nch
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_CS  = 4,
  parameter  int CLK_DIV = 2,
  localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              polarity,
  input  logic              phase,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] data_wr,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] data_rd,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam int              HW    = $clog2(2 * DATA_W);
  localparam logic [HW-1:0]   HLAST = HW'(2 * DATA_W - 1);

  state_t            state_q, state_d;
  logic              tick, div_clr;
  logic [HW-1:0]     hcnt;
  logic              cpol_q, cpha_q, lsb_q;
  logic [CSW-1:0]    cs_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              lsb_in;
  logic [DATA_W-1:0] tx_load, rx_word;
  logic              half_end, lead, trail;
  logic              sample_on_lead, sample_ev, shift_ev;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // LSB-first is handled by reversing the word at the edges of the datapath,
  // so the shift registers always run MSB first.
  assign tx_load = lsb_in ? bit_rev(data_wr) : data_wr;
  assign rx_word = lsb_q  ? bit_rev(rx_sr)   : rx_sr;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Each tick in XFER ends a half-period and toggles spi_clk. Even hcnt ends
  // on a leading edge, odd hcnt on a trailing edge.
  assign half_end = (state_q == XFER) && tick;
  assign lead     = half_end && !hcnt[0];
  assign trail    = half_end &&  hcnt[0];

  always_comb begin
    sample_on_lead = 1'b1;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_on_lead = 1'b1;
      MODE1, MODE3: sample_on_lead = 1'b0;
      default:      sample_on_lead = 1'b1;
    endcase
  end

  assign sample_ev = sample_on_lead ? lead  : trail;
  assign shift_ev  = sample_on_lead ? trail : lead;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = cs_active(state_q);
    done    = (state_q == DONE);
    cs_n    = '1;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (tick && (hcnt == HLAST)) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Out-of-range indices match no bit, so no chip select is asserted.
    for (int i = 0; i < NUM_CS; i++) begin
      if (busy && (32'(cs_q) == i)) cs_n[i] = 1'b0;
    end
    // Restart the half-period timer on every state entry; holding it clear in
    // IDLE makes the SETUP phase exactly CLK_DIV cycles long.
    div_clr = (state_d != state_q) || (state_q == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_clk <= 1'b0;
      mosi    <= 1'b0;
      data_rd <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cs_q    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      hcnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          spi_clk <= polarity;
          if (start) begin
            cpol_q <= polarity;
            cpha_q <= phase;
            cs_q   <= cs_sel;
            lsb_q  <= lsb_in;
            hcnt   <= '0;
            rx_sr  <= '0;
            // CPHA=0 needs the first bit on mosi before the first leading
            // edge; CPHA=1 drives it on that edge instead.
            if (!phase) begin
              mosi  <= tx_load[DATA_W-1];
              tx_sr <= tx_load << 1;
            end else begin
              tx_sr <= tx_load;
            end
          end
        end
        XFER: begin
          if (half_end) begin
            spi_clk <= ~spi_clk;
            if (hcnt != HLAST) hcnt <= hcnt + HW'(1);
            if (sample_ev) rx_sr <= {rx_sr[DATA_W-2:0], miso};
            if (shift_ev) begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= tx_sr << 1;
            end
          end
        end
        // Load on the HOLD->DONE edge so data_rd is already valid while done
        // is high.
        HOLD: if (tick) data_rd <= rx_word;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_spi_master_nch.sv
module tb_spi_master_nch;

  localparam int DATA_W      = 8;
  localparam int NUM_CS      = 4;
  localparam int CLK_DIV     = 2;
  localparam int EXP_DONE    = 1 + CLK_DIV * (2 * DATA_W + 2); // 37 cycles after start edge
  localparam int EXP_TOGGLES = 2 * DATA_W;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start    = 1'b0;
  logic              polarity = 1'b0;
  logic              phase    = 1'b0;
  logic [1:0]        cs_sel   = 2'd0;
  logic [DATA_W-1:0] data_wr  = '0;
  logic              lsb_first = 1'b0;
  logic              miso;
  logic              spi_clk;
  logic [NUM_CS-1:0] cs_n;
  logic              mosi;
  logic [DATA_W-1:0] data_rd;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [3:0] cs_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // slave on chip select 3: mode-0 slave presenting slave_byte MSB first,
  // advancing one bit per falling spi_clk while selected
  logic       slave_mode = 1'b0;
  logic [7:0] slave_byte = 8'h5C;
  logic [3:0] slave_cnt  = 4'd0;

  always @(negedge spi_clk or posedge cs_n[3]) begin
    if (cs_n[3]) slave_cnt <= 4'd0;
    else         slave_cnt <= slave_cnt + 4'd1;
  end

  assign miso = slave_mode ? ((slave_cnt < 4'd8) ? slave_byte[3'(4'd7 - slave_cnt)] : 1'b0)
                           : mosi;

  spi_master_nch #(
    .DATA_W  (DATA_W),
    .NUM_CS  (NUM_CS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .polarity  (polarity),
    .phase     (phase),
    .cs_sel    (cs_sel),
    .data_wr   (data_wr),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .miso      (miso),
    .spi_clk   (spi_clk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .data_rd   (data_rd),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transfer. Host inputs are scrambled right after the start edge to
  // show that mid-transfer changes are ignored.
  task automatic run_xfer(input logic [1:0] mode, input logic [7:0] wdata,
                          input logic [1:0] cs, input logic [3:0] exp_cs,
                          input logic [7:0] exp_rd, input logic hold);
    int   cyc;
    int   toggles;
    int   bad;
    int   n;
    logic prev_clk;
    logic prev_mosi;
    logic sample_edge;
    logic first_bit;
    @(negedge clk);
    polarity = mode[1];
    phase    = mode[0];
    cs_sel   = cs;
    data_wr  = wdata;
    @(negedge clk);
    check("idle_clk", 32'(spi_clk), 32'(mode[1]));
    start = 1'b1;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    polarity = ~mode[1];
    phase    = ~mode[0];
    cs_sel   = ~cs;
    data_wr  = ~wdata;
    cyc = 1;
    check("setup_busy",  32'(busy),  32'd1);
    check("setup_cs_n",  32'(cs_n),  32'(exp_cs));
    check("setup_state", 32'(state), 32'd1);
    first_bit = lsb_first ? wdata[0] : wdata[7];
    if (!mode[0]) check("first_mosi", 32'(mosi), 32'(first_bit));
    toggles   = 0;
    bad       = 0;
    prev_clk  = spi_clk;
    prev_mosi = mosi;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (spi_clk != prev_clk) begin
        toggles++;
        sample_edge = mode[0] ? (toggles % 2 == 0) : (toggles % 2 == 1);
        if (sample_edge && (mosi != prev_mosi)) bad++;
      end
      prev_clk  = spi_clk;
      prev_mosi = mosi;
    end
    check("done_seen",    32'(done),    32'd1);
    check("done_cycle",   32'(cyc),     32'(EXP_DONE));
    check("clk_toggles",  32'(toggles), 32'(EXP_TOGGLES));
    check("mosi_stable",  32'(bad),     32'd0);
    check("data_rd",      32'(data_rd), 32'(exp_q.pop_front()));
    check("done_cs_n",    32'(cs_n),    32'hF);
    check("done_busy",    32'(busy),    32'd0);
    check("done_state",   32'(state),   32'd4);
    @(posedge clk); #1;
    check("done_pulse",   32'(done),    32'd0);
    check("back_idle",    32'(state),   32'd0);
    if (hold) begin
      @(posedge clk); #1;
      check("restart_setup", 32'(state), 32'd1);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("second_done", 32'(done), 32'd1);
    end
  endtask

  task automatic reset_mid();
    int n;
    int xc;
    @(negedge clk);
    polarity = 1'b1;
    phase    = 1'b0;
    cs_sel   = 2'd2;
    data_wr  = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n  = 0;
    xc = 0;
    while (xc < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (state == 3'd2) xc++;
    end
    check("xfer_reached", 32'(xc), 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_cs_n",    32'(cs_n),    32'hF);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_data_rd", 32'(data_rd), 32'd0);
    check("rst_state",   32'(state),   32'd0);
    check("rst_mosi",    32'(mosi),    32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",   32'(state),   32'd0);
    check("reset_spi_clk", 32'(spi_clk), 32'd0);
    check("reset_cs_n",    32'(cs_n),    32'hF);
    check("reset_mosi",    32'(mosi),    32'd0);
    check("reset_data_rd", 32'(data_rd), 32'd0);
    check("reset_busy",    32'(busy),    32'd0);
    check("reset_done",    32'(done),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // all four modes, loopback, one chip select each
    for (int m = 0; m < 4; m++) begin
      run_xfer(2'(m), 8'hAB, 2'(m), cs_tab[m], 8'hAB, 1'b0);
    end

    // slave returning 0x5C on chip select 3
    slave_mode = 1'b1;
    run_xfer(2'b00, 8'h3C, 2'd3, 4'b0111, 8'h5C, 1'b0);
    slave_mode = 1'b0;

    // start held high through the transfer
    run_xfer(2'b01, 8'h96, 2'd1, 4'b1101, 8'h96, 1'b1);

    // a different pattern in mode 2
    run_xfer(2'b10, 8'h01, 2'd0, 4'b1110, 8'h01, 1'b0);

    reset_mid();

`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'b1;
    run_xfer(2'b00, 8'h01, 2'd2, 4'b1011, 8'h01, 1'b0);
    run_xfer(2'b01, 8'hA0, 2'd1, 4'b1101, 8'hA0, 1'b0);
    lsb_first = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
